// File: rtl/vga_stream_capture.sv
// rtl/vga_stream_capture.sv - captures one armed frame of a sync/img pixel stream into a frame-buffer write port
// Optional macro CAPTURE_GRAY_EN: write {Y,Y,Y} luma instead of {r,g,b}.
module vga_stream_capture #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int X_OFFSET = 128,
   parameter int WIN_W    = 512,
   parameter int WIN_H    = 480,
   parameter int ADDR_W   = 18
) (
   input  logic              vga_clk,
   input  logic              reset,
   input  logic              hsync,
   input  logic              vsync,
   input  logic              img,
   input  logic [7:0]        r,
   input  logic [7:0]        g,
   input  logic [7:0]        b,
   input  logic              arm,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [23:0]       wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              err_line,
   output logic              err_frame,
   output logic [9:0]        lines_out
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_t;

   localparam logic [9:0]        X_LO     = 10'(X_OFFSET);
   localparam logic [9:0]        X_HI     = 10'(X_OFFSET + WIN_W);
   localparam logic [9:0]        Y_LIM    = 10'(WIN_H);
   localparam logic [9:0]        H_LEN    = 10'(H_ACTIVE);
   localparam logic [9:0]        V_LEN    = 10'(V_ACTIVE);
   localparam logic [9:0]        CNT_MAX  = 10'h3ff;
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LINE_INC = ADDR_W'(WIN_W);

   state_t state_q, state_d;
   logic hsync_q, hsync_d, vsync_q, vsync_d, img_q, img_d;
   logic vsync_p_q, vsync_p_d, img_p_q, img_p_d;
   logic [23:0] rgb_q, rgb_d;
   logic [9:0] x_q, x_d, y_q, y_d, lines_q, lines_d;
   logic [ADDR_W-1:0] addr_q, addr_d, line_base_q, line_base_d;
   logic pix_we_q, pix_we_d;
   logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
   logic [23:0] pix_data_q, pix_data_d;
   logic wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [23:0] wr_data_q, wr_data_d;
   logic busy_q, busy_d, frame_done_q, frame_done_d;
   logic err_line_q, err_line_d, err_frame_q, err_frame_d;
   logic [9:0] lines_out_q, lines_out_d;

   logic vs_fall, vs_rise, img_fall, hs_bad;
   logic [9:0] lines_inc, lines_fin;
`ifdef CAPTURE_GRAY_EN
   logic [9:0] gray_sum;
`endif

   always_comb begin
      hsync_d      = hsync;
      vsync_d      = vsync;
      img_d        = img;
      rgb_d        = {r, g, b};
      vsync_p_d    = vsync_q;
      img_p_d      = img_q;

      vs_fall      = vsync_p_q & ~vsync_q;
      vs_rise      = ~vsync_p_q & vsync_q;
      img_fall     = img_p_q & ~img_q;
      // visible pixels during the hsync pulse mean the source timing is broken
      hs_bad       = img_q & ~hsync_q;
      lines_inc    = (lines_q == CNT_MAX) ? lines_q : lines_q + 10'd1;
      lines_fin    = img_fall ? lines_inc : lines_q;

      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      lines_d      = lines_q;
      addr_d       = addr_q;
      line_base_d  = line_base_q;
      pix_we_d     = 1'b0;
      pix_addr_d   = addr_q;
      pix_data_d   = rgb_q;
      frame_done_d = 1'b0;
      err_line_d   = err_line_q;
      err_frame_d  = err_frame_q;
      lines_out_d  = lines_out_q;

      wr_en_d      = pix_we_q;
      wr_addr_d    = pix_addr_q;
`ifdef CAPTURE_GRAY_EN
      gray_sum     = {2'b00, pix_data_q[23:16]} + {1'b0, pix_data_q[15:8], 1'b0}
                   + {2'b00, pix_data_q[7:0]};
      wr_data_d    = {gray_sum[9:2], gray_sum[9:2], gray_sum[9:2]};
`else
      wr_data_d    = pix_data_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (arm) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (vs_rise) begin
               x_d         = '0;
               y_d         = '0;
               lines_d     = '0;
               addr_d      = '0;
               line_base_d = '0;
               err_line_d  = 1'b0;
               err_frame_d = 1'b0;
               state_d     = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (img_q) begin
               if (x_q != CNT_MAX) x_d = x_q + 10'd1;
               if (x_q >= X_LO && x_q < X_HI && y_q < Y_LIM) begin
                  pix_we_d = 1'b1;
                  addr_d   = addr_q + ADDR_ONE;
               end
            end
            if (hs_bad) err_line_d = 1'b1;
            // reload from the line base so a short line cannot shift later lines
            if (img_fall) begin
               if (x_q != H_LEN) err_line_d = 1'b1;
               x_d         = '0;
               y_d         = (y_q == CNT_MAX) ? y_q : y_q + 10'd1;
               lines_d     = lines_inc;
               line_base_d = line_base_q + LINE_INC;
               addr_d      = line_base_q + LINE_INC;
            end
            if (vs_fall) begin
               lines_out_d  = lines_fin;
               if (lines_fin != V_LEN) err_frame_d = 1'b1;
               frame_done_d = 1'b1;
               state_d      = arm ? S_ARMED : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         hsync_q      <= 1'b0;
         vsync_q      <= 1'b0;
         img_q        <= 1'b0;
         vsync_p_q    <= 1'b0;
         img_p_q      <= 1'b0;
         rgb_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         lines_q      <= '0;
         addr_q       <= '0;
         line_base_q  <= '0;
         pix_we_q     <= 1'b0;
         pix_addr_q   <= '0;
         pix_data_q   <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         err_line_q   <= 1'b0;
         err_frame_q  <= 1'b0;
         lines_out_q  <= '0;
      end else begin
         state_q      <= state_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         img_q        <= img_d;
         vsync_p_q    <= vsync_p_d;
         img_p_q      <= img_p_d;
         rgb_q        <= rgb_d;
         x_q          <= x_d;
         y_q          <= y_d;
         lines_q      <= lines_d;
         addr_q       <= addr_d;
         line_base_q  <= line_base_d;
         pix_we_q     <= pix_we_d;
         pix_addr_q   <= pix_addr_d;
         pix_data_q   <= pix_data_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         err_line_q   <= err_line_d;
         err_frame_q  <= err_frame_d;
         lines_out_q  <= lines_out_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign err_line   = err_line_q;
   assign err_frame  = err_frame_q;
   assign lines_out  = lines_out_q;

endmodule
